reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- General-purpose register file: 8 entries of WIDTH bits, two asynchronous (combinational) read ports, one synchronous write port.
- Serves as the operand store of the datapath: the decode stage drives ra1/ra2; the writeback stage drives wa3/wd3/we3.
- Register 0 is hardwired to zero.

Parameters:
- WIDTH, 8, data width of each register and of rd1, rd2, wd3.
- ADDR_W, 3, address width; entry count = 2**ADDR_W (8 by default).

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all registers.
- we3  input  1  write enable for write port 3.
- wa3  input  ADDR_W  write address.
- wd3  input  WIDTH  write data.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: registers r0..r7, each WIDTH bits.

Reset:
- rst_n low clears every register to 0 immediately, independent of clk.
- While rst_n is low, rd1 = rd2 = 0 and writes are blocked.
- On release of rst_n, the first write can take effect at the next rising clk edge.

Write:
- On the rising edge of clk with rst_n high and we3 = 1, r[wa3] <= wd3.
- we3 = 0 leaves all registers unchanged.
- A write to wa3 = 0 is silently discarded; r0 always holds 0.

Read:
- Purely combinational: rd1 = r[ra1] and rd2 = r[ra2]. No clock latency; outputs follow address changes in the same delta cycle.
- ra = 0 returns 0 on either port.
- Both ports may address the same register simultaneously and each returns its value independently.

Read/write collision:
- No internal bypass.
- With ra1 or ra2 equal to wa3 (nonzero) and we3 = 1, the read port shows the old value until the rising edge, then the new value (visible combinationally right after the edge).

Width and X rules:
- wd3 is stored unmodified, with no sign or zero extension.
- Address inputs cover all 2**ADDR_W entries, so there are no out-of-range cases.
- X/Z on addresses need not be handled; synthesis treats the read muxes as full case.

Write latency:
- One clock edge from presenting we3/wa3/wd3 to data being readable.

Test Plan:
1. Reset: drive rst_n = 0 mid-simulation after several writes -> all ra1/ra2 values 0..7 read 0x00 immediately, without waiting for a clock edge.
2. Write chain, one write per cycle with we3 = 1:
   - Writes: r1 = 0x8A, r2 = 0xAA, r3 = 0xCA, r4 = 0xEA, r5 = 0xAA, r6 = 0x8E, r7 = 0xFF.
   - In each cycle, ra1 points at the register written the previous cycle and ra2 at the one written two cycles earlier.
   - Expected: rd1/rd2 match the previously written values, e.g. ra1 = 3, ra2 = 2 -> rd1 = 0xCA, rd2 = 0xAA.
3. Write disable: we3 = 0, wa3 = 0, wd3 = 0x0A; then we3 = 0, wa3 = 5, wd3 = 0x55 -> r5 still reads 0xAA and r0 reads 0x00.
4. Register zero: we3 = 1, wa3 = 0, wd3 = 0xFF -> after the edge, rd1 (ra1 = 0) = 0x00.
5. Same-address read/write: r3 = 0xCA; set ra1 = ra2 = wa3 = 3, we3 = 1, wd3 = 0x8A.
   - Before the rising edge: rd1 = rd2 = 0xCA.
   - After the edge: rd1 = rd2 = 0x8A.
6. Combinational read: hold clk static and sweep ra1 over 0..7 -> rd1 follows each address with zero cycles of latency, returning the stored values.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Eight-entry general-purpose register file: two combinational read ports, one
// synchronous write port, with register 0 hardwired to zero.
module reg_file_2r1w #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [WIDTH-1:0]  wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic             w_wr_en;

    // Writes to entry 0 are dropped here so r_regs[0] keeps its reset value of 0.
    assign w_wr_en = we3 && (wa3 != '0);

    // NOTE: this array is built from flops rather than a RAM macro, so clearing
    // every entry on reset is legal and cheap; a RAM could not be reset this way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: non-blocking assignment for all clocked state, so every
                // flop samples pre-edge values regardless of statement order.
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wa3] <= wd3;
        end
    end

    // No write bypass: a read of the register being written shows the old value
    // until the clock edge commits the new one.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        w_rd1 = '0;
        w_rd2 = '0;
        if (ra1 != '0) begin
            w_rd1 = r_regs[ra1];
        end
        if (ra2 != '0) begin
            w_rd2 = r_regs[ra2];
        end
    end

    assign rd1 = w_rd1;
    assign rd2 = w_rd2;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w: reset, write chain, write
// disable, register zero, same-address collision and combinational read sweep.
module tb_reg_file_2r1w;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] rd1;
    logic [7:0] rd2;

    int n_tests;
    int n_fail;

    logic [7:0] chain_vals [8];
    logic [7:0] exp_regs   [8];

    reg_file_2r1w #(
        .WIDTH  (8),
        .ADDR_W (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we3   (we3),
        .wa3   (wa3),
        .wd3   (wd3),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change only in the low phase, well away from the rising edge.
    task automatic to_low_phase();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk_en  = 1'b1;
        rst_n   = 1'b0;
        we3     = 1'b0;
        wa3     = '0;
        wd3     = '0;
        ra1     = '0;
        ra2     = '0;
        chain_vals = '{8'h00, 8'h8A, 8'hAA, 8'hCA, 8'hEA, 8'hAA, 8'h8E, 8'hFF};
        for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;

        // Power-on reset state.
        repeat (2) @(posedge clk);
        ra1 = 3'd1;
        ra2 = 3'd7;
        #1;
        check("reset_rd1_r1", rd1, 8'h00);
        check("reset_rd2_r7", rd2, 8'h00);
        to_low_phase();
        rst_n = 1'b1;

        // Write chain: ra1 trails by one write, ra2 by two.
        for (int k = 1; k < 8; k++) begin
            to_low_phase();
            we3 = 1'b1;
            wa3 = 3'(k);
            wd3 = chain_vals[k];
            ra1 = 3'(k - 1);
            ra2 = (k >= 2) ? 3'(k - 2) : 3'd0;
            #1;
            check($sformatf("chain_k%0d_rd1", k), rd1, exp_regs[ra1]);
            check($sformatf("chain_k%0d_rd2", k), rd2, exp_regs[ra2]);
            @(posedge clk);
            exp_regs[k] = chain_vals[k];
        end
        to_low_phase();
        we3 = 1'b0;
        ra1 = 3'd7;
        ra2 = 3'd6;
        #1;
        check("chain_final_rd1_r7", rd1, 8'hFF);
        check("chain_final_rd2_r6", rd2, 8'h8E);
        ra1 = 3'd3;
        ra2 = 3'd2;
        #1;
        check("chain_rd1_r3", rd1, 8'hCA);
        check("chain_rd2_r2", rd2, 8'hAA);

        // Write disable.
        we3 = 1'b0;
        wa3 = 3'd0;
        wd3 = 8'h0A;
        @(posedge clk);
        to_low_phase();
        we3 = 1'b0;
        wa3 = 3'd5;
        wd3 = 8'h55;
        @(posedge clk);
        #1;
        ra1 = 3'd5;
        ra2 = 3'd0;
        #1;
        check("wdis_rd1_r5", rd1, 8'hAA);
        check("wdis_rd2_r0", rd2, 8'h00);

        // Write to register zero is discarded.
        to_low_phase();
        we3 = 1'b1;
        wa3 = 3'd0;
        wd3 = 8'hFF;
        ra1 = 3'd0;
        ra2 = 3'd0;
        @(posedge clk);
        #1;
        check("r0_rd1", rd1, 8'h00);
        check("r0_rd2", rd2, 8'h00);

        // Same-address read/write: old value before the edge, new value after.
        to_low_phase();
        we3 = 1'b1;
        wa3 = 3'd3;
        wd3 = 8'h8A;
        ra1 = 3'd3;
        ra2 = 3'd3;
        #1;
        check("coll_pre_rd1", rd1, 8'hCA);
        check("coll_pre_rd2", rd2, 8'hCA);
        @(posedge clk);
        #1;
        check("coll_post_rd1", rd1, 8'h8A);
        check("coll_post_rd2", rd2, 8'h8A);
        exp_regs[3] = 8'h8A;

        // Combinational read sweep with the clock stopped.
        @(negedge clk);
        clk_en = 1'b0;
        we3    = 1'b0;
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(7 - a);
            #1;
            check($sformatf("sweep_rd1_a%0d", a), rd1, exp_regs[a]);
            check($sformatf("sweep_rd2_a%0d", 7 - a), rd2, exp_regs[7 - a]);
        end

        // Asynchronous reset mid-simulation, clock still stopped.
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(a);
            #1;
            check($sformatf("areset_rd1_a%0d", a), rd1, 8'h00);
            check($sformatf("areset_rd2_a%0d", a), rd2, 8'h00);
        end

        // Writes blocked while reset is held.
        clk_en = 1'b1;
        we3    = 1'b1;
        wa3    = 3'd2;
        wd3    = 8'h33;
        ra1    = 3'd2;
        @(posedge clk);
        #1;
        check("reset_block_wr", rd1, 8'h00);

        // First write after release lands on the next rising edge.
        to_low_phase();
        rst_n = 1'b1;
        #1;
        check("release_pre_edge", rd1, 8'h00);
        @(posedge clk);
        #1;
        check("release_first_wr", rd1, 8'h33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
